// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential word requests, in-order response buffer, redirect flush.
// Optional FETCH_STATS_EN adds a saturating discarded-response counter (fetch_drop_count).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] fetch_drop_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] inflight_cnt;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] infl_head, infl_tail;
    logic [PW-1:0] buf_head, buf_tail;

    logic [31:0] infl_pc  [DEPTH];
    logic [31:0] buf_inst [DEPTH];
    logic [31:0] buf_pc   [DEPTH];

    logic req_fire;
    logic resp_ok;
    logic keep;
    logic discard;
    logic fetch_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both outstanding requests and buffered entries, so the buffer cannot overflow.
    assign imem_req_valid = !redirect_valid &&
                            (({1'b0, inflight_cnt} + {1'b0, buf_cnt}) < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored entirely.
    assign resp_ok    = imem_resp_valid && (inflight_cnt != '0);
    assign keep       = resp_ok && !redirect_valid && (drop_cnt == '0);
    assign discard    = resp_ok && (redirect_valid || (drop_cnt != '0));

    assign fetch_valid = (buf_cnt != '0);
    assign fetch_fire  = fetch_valid && fetch_ready && !redirect_valid;
    assign fetch_inst  = fetch_valid ? buf_inst[buf_head] : '0;
    assign fetch_pc    = fetch_valid ? buf_pc[buf_head]   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            inflight_cnt <= '0;
            buf_cnt      <= '0;
            drop_cnt     <= '0;
            infl_head    <= '0;
            infl_tail    <= '0;
            buf_head     <= '0;
            buf_tail     <= '0;
        end else begin
            inflight_cnt <= inflight_cnt + CW'(req_fire) - CW'(resp_ok);
            if (req_fire) infl_tail <= ptr_inc(infl_tail);
            if (resp_ok)  infl_head <= ptr_inc(infl_head);

            if (redirect_valid) begin
                pc       <= redirect_pc & ~32'h3;
                buf_cnt  <= '0;
                buf_head <= '0;
                buf_tail <= '0;
                drop_cnt <= inflight_cnt - CW'(resp_ok);
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                buf_cnt <= buf_cnt + CW'(keep) - CW'(fetch_fire);
                if (keep)       buf_tail <= ptr_inc(buf_tail);
                if (fetch_fire) buf_head <= ptr_inc(buf_head);
                if (discard)    drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (req_fire) infl_pc[infl_tail] <= pc;
        if (keep) begin
            buf_inst[buf_tail] <= imem_resp_data;
            buf_pc[buf_tail]   <= infl_pc[infl_head];
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_drop_count <= '0;
        end else if (discard && (fetch_drop_count != 16'hFFFF)) begin
            fetch_drop_count <= fetch_drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against an
// epoch-tagged memory/scoreboard model.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_drop_count;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fetch_valid     (fetch_valid),
        .fetch_inst      (fetch_inst),
        .fetch_pc        (fetch_pc),
        .fetch_ready     (fetch_ready)
`ifdef FETCH_STATS_EN
        ,
        .fetch_drop_count(fetch_drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    pend_t       pend[$];
    ent_t        buf_q[$];
    logic [31:0] pc_m;
    int          epoch;
    int          cyc;
    int          last_due;
    int          lat_max;
    int          drops_m;
    int          obs_fires;
    logic [31:0] obs_pcs[$];

    int checks;
    int errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic model_clear();
        pend.delete();
        buf_q.delete();
        obs_pcs.delete();
        pc_m      = RESET_PC;
        epoch     = 0;
        cyc       = 0;
        last_due  = -1;
        drops_m   = 0;
        obs_fires = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rq, input logic fr);
        logic  rsp;
        logic  exp_rv;
        logic  kept;
        pend_t h;
        ent_t  e;
        int    due;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        fetch_ready    = fr;
        rsp = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? mem_word(pend[0].addr) : $urandom();
        #2;
        exp_rv = !rv && ((pend.size() + buf_q.size()) < DEPTH);
        checks++;
        if (imem_req_valid !== exp_rv) begin
            errors++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
        end
        checks++;
        if (imem_req_addr !== pc_m) begin
            errors++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc_m);
        end
        checks++;
        if (fetch_valid !== (buf_q.size() != 0)) begin
            errors++;
            $display("FAIL fetch_valid cyc=%0d got=%b exp=%b", cyc, fetch_valid, buf_q.size() != 0);
        end
        if (buf_q.size() != 0) begin
            checks++;
            if (fetch_pc !== buf_q[0].pc || fetch_inst !== buf_q[0].inst) begin
                errors++;
                $display("FAIL fetch_head cyc=%0d got=%h/%h exp=%h/%h", cyc,
                         fetch_pc, fetch_inst, buf_q[0].pc, buf_q[0].inst);
            end
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (fetch_drop_count !== ((drops_m > 65535) ? 16'hFFFF : 16'(drops_m))) begin
            errors++;
            $display("FAIL drop_count cyc=%0d got=%0d exp=%0d", cyc, fetch_drop_count, drops_m);
        end
`endif
        if (imem_req_valid && imem_req_ready) obs_fires++;
        if (fetch_valid && fetch_ready && !rv) obs_pcs.push_back(fetch_pc);

        kept = 1'b0;
        if (rsp) begin
            h = pend.pop_front();
            if (rv || h.epoch != epoch) begin
                drops_m++;
            end else begin
                kept = 1'b1;
                e = '{mem_word(h.addr), h.addr};
            end
        end
        if (!rv && buf_q.size() != 0 && fr) void'(buf_q.pop_front());
        if (kept) buf_q.push_back(e);
        if (exp_rv && rq) begin
            due = cyc + int'($urandom_range(1, lat_max));
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{pc_m, epoch, due});
            last_due = due;
            pc_m = pc_m + 32'd4;
        end
        if (rv) begin
            buf_q.delete();
            epoch++;
            pc_m = rpc & ~32'h3;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        fetch_ready     = 1'b0;
        reset = 1'b1;
        #2;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL async_reset got valid=%b addr=%h exp 0/%h", fetch_valid, imem_req_addr, RESET_PC);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_req got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        checks++;
        if (fetch_valid !== 1'b0 || fetch_inst !== 32'h0 || fetch_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch got %b/%h/%h exp 0/0/0", fetch_valid, fetch_inst, fetch_pc);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (fetch_drop_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_drop_count got %0d exp 0", fetch_drop_count);
        end
`endif
    endtask

    task automatic test_stream();
        test_reset();
        lat_max = 1;
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (obs_pcs.size() < 3 || obs_pcs[0] !== 32'h100 || obs_pcs[1] !== 32'h104 || obs_pcs[2] !== 32'h108) begin
            errors++;
            $display("FAIL stream_order got n=%0d exp 100,104,108 first", obs_pcs.size());
        end
    endtask

    task automatic test_backpressure();
        test_reset();
        lat_max = 1;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (obs_fires != DEPTH) begin
            errors++;
            $display("FAIL bp_req_count got %0d exp %0d", obs_fires, DEPTH);
        end
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (obs_pcs.size() < 2 || obs_pcs[0] !== 32'h100 || obs_pcs[1] !== 32'h104) begin
            errors++;
            $display("FAIL bp_drain got n=%0d exp 100,104", obs_pcs.size());
        end
    endtask

    task automatic test_req_stall();
        test_reset();
        lat_max = 2;
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs_fires != 0 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL stall_hold got fires=%0d addr=%h exp 0/%h", obs_fires, imem_req_addr, RESET_PC);
        end
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_redirect_same_cycle();
        test_reset();
        lat_max = 1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h2000, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (obs_pcs.size() == 0 || obs_pcs[0] !== 32'h2000) begin
            errors++;
            $display("FAIL redir_first_pc got n=%0d exp first 2000", obs_pcs.size());
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (fetch_drop_count !== 16'd1) begin
            errors++;
            $display("FAIL redir_drops got %0d exp 1", fetch_drop_count);
        end
`endif
    endtask

    task automatic test_redirect_inflight();
        test_reset();
        lat_max = 3;
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h2002, 1'b1, 1'b1);
        checks++;
        if (imem_req_addr !== 32'h2000 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_after got addr=%h valid=%b exp 2000/0", imem_req_addr, fetch_valid);
        end
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        test_reset();
        lat_max = 1;
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap got %h exp 00000000", imem_req_addr);
        end
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            step($urandom_range(0, 11) == 0, rpc, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0);
        end
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        lat_max = 1;
        reset   = 1'b1;
        model_clear();
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        fetch_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_same_cycle();
        test_redirect_inflight();
        test_wrap();
        test_random();
        test_reset();
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
